// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package rf_pkg;

  localparam int unsigned RF_DATA_W       = 8;
  localparam int unsigned RF_ADDR_W       = 3;
  localparam int unsigned RF_NUM_REGS     = 8;
  localparam int unsigned RF_STARVE_LIMIT = 3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wr_prio.sv
// Two-input write-port priority grant with ALU starvation protection.
// MEM normally wins a tie; after STARVE_LIMIT consecutive ALU denials the
// ALU wins the next tie.
// Ports:
//   clk, rst             clock, async active-high reset
//   alu_valid, mem_valid request lines
//   enable               grants allowed (arbitration state)
//   alu_grant, mem_grant combinational one-hot-or-zero grants
module rf_wr_prio #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic mem_valid,
  input  logic enable,
  output logic alu_grant,
  output logic mem_grant
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grant decision; ALU wins when alone or when starved.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (enable) begin
      if (alu_valid && (!mem_valid || starved)) begin
        alu_grant = 1'b1;
      end else if (mem_valid) begin
        mem_grant = 1'b1;
      end
    end
  end

  // Consecutive-denial counter, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_grant) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Owns the register-file write port: zero-fills all registers after reset or
// on CLEAR_REQ, otherwise forwards one ALU or load write per cycle.
// Ports:
//   CLK, RESET                         clock, async active-high reset
//   ALU_VALID/ADDR/DATA, ALU_READY     ALU writeback request / accept
//   MEM_VALID/ADDR/DATA, MEM_READY     load writeback request / accept
//   CLEAR_REQ                          pulse: start zero-fill
//   WRITE, INADDRESS, IN               registered reg_file write port
//   BUSY                               fill sequence active
module reg_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned ADDR_W       = RF_ADDR_W,
  parameter int unsigned NUM_REGS     = RF_NUM_REGS,
  parameter int unsigned STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_READY,
  input  logic              MEM_VALID,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_READY,
  input  logic              CLEAR_REQ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic              BUSY
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic              write_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              alu_grant, mem_grant;
  logic              arb_en;

  assign arb_en    = (state_q == ST_ARB);
  assign ALU_READY = alu_grant;
  assign MEM_READY = mem_grant;
  assign BUSY      = (state_q == ST_CLEAR);

  rf_wr_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (CLK),
    .rst       (RESET),
    .alu_valid (ALU_VALID),
    .mem_valid (MEM_VALID),
    .enable    (arb_en),
    .alu_grant (alu_grant),
    .mem_grant (mem_grant)
  );

  // Next state, fill pointer and next write-port value.
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    write_d    = 1'b0;
    addr_d     = INADDRESS;
    data_d     = IN;
    case (state_q)
      ST_CLEAR: begin
        write_d = 1'b1;
        addr_d  = fill_ptr_q;
        data_d  = '0;
        if (fill_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d    = ST_ARB;
          fill_ptr_d = '0;
        end else begin
          fill_ptr_d = fill_ptr_q + ADDR_W'(1);
        end
      end
      ST_ARB: begin
        if (mem_grant) begin
          write_d = 1'b1;
          addr_d  = MEM_ADDR;
          data_d  = MEM_DATA;
        end else if (alu_grant) begin
          write_d = 1'b1;
          addr_d  = ALU_ADDR;
          data_d  = ALU_DATA;
        end
        // A same-cycle transfer still lands; the fill starts next cycle.
        if (CLEAR_REQ) begin
          state_d = ST_CLEAR;
        end
      end
    endcase
  end

  // State and registered write port.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_CLEAR;
      fill_ptr_q <= '0;
      WRITE      <= 1'b0;
      INADDRESS  <= '0;
      IN         <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      WRITE      <= write_d;
      INADDRESS  <= addr_d;
      IN         <= data_d;
    end
  end

endmodule
